// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with single-word
// handshaked refill, single-cycle flush and a saturating miss counter.
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   cpu_addr           - byte fetch address (bits [1:0] ignored)
//   cpu_data/cpu_ready - instruction word / hit (fetch stalls while 0)
//   flush              - invalidate all lines
//   mem_req/mem_addr   - word read request and word-aligned byte address
//   mem_ack/mem_rdata  - memory handshake and returned word
//   miss_count         - misses started, saturating at 16'hFFFF
module icache_direct #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - 2 - OB - IB;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OB-1:0]     beat_q, beat_d;
  logic              abort_q, abort_d;
  logic              mem_req_q, mem_req_d;
  logic [15:0]       miss_q, miss_d;
  logic [31:0]       base_q, base_d;
  logic [IB-1:0]     fidx_q, fidx_d;

  // Storage arrays are never reset; only the valid bits qualify them.
  logic [31:0]       data_mem [LINES*WORDS];
  logic [TW-1:0]     tag_mem  [LINES];

  logic [OB-1:0]     off;
  logic [IB-1:0]     idx;
  logic [TW-1:0]     tag;
  logic              hit;
  logic              last_beat;

  assign off       = cpu_addr[2 +: OB];
  assign idx       = cpu_addr[2+OB +: IB];
  assign tag       = cpu_addr[31 -: TW];
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
  assign last_beat = (beat_q == OB'(WORDS-1));

  assign cpu_ready  = (state_q == S_IDLE) && hit;
  assign cpu_data   = data_mem[{idx, off}];
  assign mem_req    = mem_req_q;
  // Line base is aligned, so adding the word offset never carries into the index.
  assign mem_addr   = (state_q == S_FILL) ?
                      (base_q + {{(30-OB){1'b0}}, beat_q, 2'b00}) : 32'd0;
  assign miss_count = miss_q;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    beat_d    = beat_q;
    abort_d   = abort_q;
    mem_req_d = mem_req_q;
    miss_d    = miss_q;
    base_d    = base_q;
    fidx_d    = fidx_q;
    case (state_q)
      S_IDLE: begin
        // Flush wins over a miss in the same cycle: no fill, no count.
        if (flush) begin
          valid_d = '0;
        end else if (!hit) begin
          base_d       = {cpu_addr[31:OB+2], {(OB+2){1'b0}}};
          fidx_d       = idx;
          valid_d[idx] = 1'b0;
          beat_d       = '0;
          mem_req_d    = 1'b1;
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          state_d      = S_FILL;
        end
      end
      S_FILL: begin
        // A flush mid-fill lets the handshake finish but keeps the line invalid.
        if (flush) begin
          valid_d = '0;
          abort_d = 1'b1;
        end
        if (mem_ack) begin
          beat_d = beat_q + OB'(1);
          if (last_beat) begin
            if (!abort_q && !flush) valid_d[fidx_q] = 1'b1;
            abort_d   = 1'b0;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      beat_q    <= '0;
      abort_q   <= 1'b0;
      mem_req_q <= 1'b0;
      miss_q    <= 16'd0;
      base_q    <= 32'd0;
      fidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      beat_q    <= beat_d;
      abort_q   <= abort_d;
      mem_req_q <= mem_req_d;
      miss_q    <= miss_d;
      base_q    <= base_d;
      fidx_q    <= fidx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_FILL && mem_ack) begin
      data_mem[{fidx_q, beat_q}] <= mem_rdata;
      if (last_beat) tag_mem[fidx_q] <= base_q[31 -: TW];
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Testbench for icache_direct: directed fetches against a handshaked memory
// whose words are address ^ 0xA5A5A5A5. CPU data and memory addresses are
// checked by queue-based monitors; latency and counter checks inline.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int ack_every = 1;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  icache_direct #(.LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: ack every ack_every-th cycle of an outstanding request.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) begin
        if (cnt >= ack_every - 1) begin
          mem_ack = 1'b1;
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
      mem_rdata = mem_addr ^ 32'hA5A5A5A5;
    end
  end

  // CPU monitor: pops one expected word each time a pending fetch completes.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_ready === 1'b1 && exp_data_q.size() > 0) begin
        mon_exp = exp_data_q.pop_front();
        check("cpu_data", cpu_data, mon_exp);
      end
    end
  end

  // Memory monitor: address must equal the expected head every request cycle
  // (so it is held between acks); the head retires on ack.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_addr unexpected request actual=%h required=none", mem_addr);
        end else begin
          check("mem_addr", mem_addr, exp_addr_q[0]);
          if (mem_ack === 1'b1) exp_addr_q.delete(0);
        end
      end
    end
  end

  // Present addr (releasing reset), queue expectations, wait for cpu_ready.
  // flush is driven high during cycle flush_cyc of the fetch (-1: never).
  task automatic fetch(input logic [31:0] addr, input int fills, input int exp_lat,
                       input int flush_cyc, input string name);
    int c;
    logic [31:0] base;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cpu_addr = addr;
    exp_data_q.push_back({addr[31:2], 2'b00} ^ 32'hA5A5A5A5);
    base = {addr[31:4], 4'h0};
    for (int f = 0; f < fills; f++)
      for (int w = 0; w < 4; w++)
        exp_addr_q.push_back(base + 32'(4 * w));
    c = 0;
    forever begin
      @(negedge clk);
      if (cpu_ready === 1'b1) break;
      flush = (c == flush_cyc);
      c++;
      if (c > 200) break;
    end
    flush = 1'b0;
    check(name, c, exp_lat);
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    cpu_addr = 32'h10;
    #12;
    check("rst_cpu_ready",  {31'd0, cpu_ready}, 32'd0);
    check("rst_mem_req",    {31'd0, mem_req},   32'd0);
    check("rst_mem_addr",   mem_addr,           32'd0);
    check("rst_miss_count", {16'd0, miss_count}, 32'd0);

    // Cold miss, zero-wait memory: ready at cycle 5.
    fetch(32'h10, 1, 5, -1, "lat_cold_0x10");
    check("mc_cold", {16'd0, miss_count}, 32'd1);

    // Sequential hits through the filled line.
    fetch(32'h10, 0, 0, -1, "lat_hit_0x10");
    fetch(32'h14, 0, 0, -1, "lat_hit_0x14");
    fetch(32'h18, 0, 0, -1, "lat_hit_0x18");
    fetch(32'h1C, 0, 0, -1, "lat_hit_0x1C");
    check("mc_hits", {16'd0, miss_count}, 32'd1);

    // Conflict on index 1: tag 1 evicts tag 0, then tag 0 evicts tag 1.
    fetch(32'h110, 1, 5, -1, "lat_conflict_0x110");
    fetch(32'h10,  1, 5, -1, "lat_conflict_0x10");
    check("mc_conflict", {16'd0, miss_count}, 32'd3);

    // Memory acking every 3rd cycle: acks at 3,6,9,12, ready at 13.
    ack_every = 3;
    fetch(32'h24, 1, 13, -1, "lat_slow_0x24");
    ack_every = 1;
    check("mc_slow", {16'd0, miss_count}, 32'd4);

    // Flush in the 2nd fill beat: fill completes invalid, refetch misses.
    fetch(32'h30, 2, 10, 2, "lat_flush_fill_0x30");
    check("mc_flush_fill", {16'd0, miss_count}, 32'd6);

    // Flush in idle turns a hit into a miss.
    fetch(32'h30, 0, 0, -1, "lat_hit_0x30");
    @(posedge clk);
    #1;
    flush = 1'b1;
    fetch(32'h30, 1, 5, -1, "lat_after_flush_0x30");
    check("mc_idle_flush", {16'd0, miss_count}, 32'd7);

    // Flush coinciding with a miss blocks the fill for that cycle.
    fetch(32'h50, 1, 6, 0, "lat_flush_prio_0x50");
    check("mc_flush_prio", {16'd0, miss_count}, 32'd8);

    // Reset pulse in the middle of a fill.
    @(posedge clk);
    #1;
    cpu_addr = 32'h40;
    for (int w = 0; w < 4; w++) exp_addr_q.push_back(32'h40 + 32'(4 * w));
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_mem_req",    {31'd0, mem_req},    32'd0);
    check("midrst_cpu_ready",  {31'd0, cpu_ready},  32'd0);
    check("midrst_miss_count", {16'd0, miss_count}, 32'd0);
    check("midrst_mem_addr",   mem_addr,            32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    fetch(32'h40, 1, 5, -1, "lat_after_reset_0x40");
    check("mc_after_reset", {16'd0, miss_count}, 32'd1);
    fetch(32'h4C, 0, 0, -1, "lat_hit_0x4C");

    @(posedge clk);
    #1;
    if (exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expectations actual=%0d/%0d required=0/0",
               exp_data_q.size(), exp_addr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the CPU's instruction fetch port and a slower, handshaked instruction memory. Hits return the instruction word combinationally in the cycle the fetch address is presented. Misses stall the fetch via `cpu_ready` while a refill FSM reads the whole line from memory, one word per handshake. The block also provides a single-cycle flush and a saturating miss counter for performance bring-up.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `cpu_addr` input 32: byte fetch address from the fetch stage; bits [1:0] ignored.
- `cpu_data` output 32: instruction word; valid only when `cpu_ready`=1.
- `cpu_ready` output 1: hit; the fetch stage must hold `cpu_addr` and stall while this is 0.
- `flush` input 1: invalidate all lines.
- `mem_req` output 1: word read request to instruction memory.
- `mem_addr` output 32: word-aligned byte address of the requested word.
- `mem_ack` input 1: memory returns `mem_rdata` this cycle; ignored unless `mem_req`=1.
- `mem_rdata` input 32: returned word.
- `miss_count` output 16: number of misses started, saturating at 16'hFFFF.

## Operation
- Address split:
  - offset = `cpu_addr`[2+OB-1:2], with OB = log2(WORDS).
  - index = the next IB bits, with IB = log2(LINES).
  - tag = the remaining upper 32-2-OB-IB bits.
- Storage: data array LINES×WORDS×32, tag array LINES×tag width, valid bit per line.
- States: IDLE and FILL.
- In IDLE:
  - `cpu_ready` = valid[index] AND tag match; `cpu_data` = data[index][offset], combinational.
  - On a miss, the rising edge does the following:
    - captures line base = {tag, index, OB+2 zero bits} and the index;
    - clears valid[index];
    - sets beat to 0 and `mem_req` to 1;
    - increments `miss_count`;
    - moves to FILL.
- In FILL:
  - `cpu_ready`=0 regardless of `cpu_addr`.
  - `mem_addr` = base + 4·beat. `mem_req` and `mem_addr` stay stable until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` into data[captured index][beat], then increment beat.
  - On the ack of beat WORDS-1:
    - write the captured tag;
    - set valid, unless the fill is aborted;
    - clear `mem_req`;
    - return to IDLE.
- Flush:
  - In IDLE, clears all valid bits at the edge. Flush has priority over miss handling in that cycle: no fill starts and `miss_count` does not increment.
  - In FILL, clears all valid bits and marks the fill aborted. The fill still runs to completion so the memory handshake is never abandoned, but the line is not validated. The abort mark clears on return to IDLE.
- `miss_count` never wraps. Flush does not clear it.
- Data and tag arrays are not reset. Only valid bits, state, beat, abort, `mem_req` and `miss_count` are reset.

## Timing
- Reset values:
  - state IDLE, all valid bits 0, beat 0, abort 0;
  - `mem_req` 0, `miss_count` 0, `cpu_ready` 0;
  - `mem_addr` 0 while idle; `cpu_data` is don't-care.
- Hit latency: 0 cycles, combinational from `cpu_addr`.
- Miss with zero-wait memory (`mem_ack` high every cycle):
  - miss seen in cycle 0;
  - `mem_req` high in cycles 1 through WORDS;
  - `cpu_ready`=1 in cycle WORDS+1 (cycle 5 with defaults).
- Each wait state on `mem_ack` adds exactly 1 cycle.
- One word per ack; no back-to-back ack is lost, so ack may stay high continuously.
- Asynchronous reset during FILL returns to IDLE immediately and drops `mem_req`. Memory must tolerate an abandoned request.
- A `cpu_addr` change during FILL does not affect the fill. After return to IDLE, the current address is looked up fresh, and a different address may cause an immediate new miss.

## Test plan
- Cold fetch at 0x10 after reset, zero-wait memory returning `mem_addr`^0xA5A5A5A5:
  - `mem_addr` sequence 0x10, 0x14, 0x18, 0x1C;
  - `cpu_ready`=1 at cycle 5 with `cpu_data`=0xA5A5A5B5;
  - `miss_count`=1.
- Sequential fetches 0x10→0x1C after the fill: `cpu_ready`=1 every cycle with the correct words; `miss_count` stays 1.
- Conflict: fill 0x10, fetch 0x110 (same index, tag 1), then fetch 0x10 again → three misses, `miss_count`=3, correct data each time.
- Memory with `mem_ack` every 3rd cycle: `mem_addr` is held between acks and `cpu_ready` rises 1 cycle after the 4th ack.
- Flush asserted in the 2nd FILL beat: the fill completes, then a fetch of the same address misses again; a flush in IDLE makes a hit address miss on the next fetch.
- Reset pulse mid-fill: `mem_req`=0 and `cpu_ready`=0 immediately; `miss_count`=0. A subsequent fetch refills correctly.
